// File: rtl/mux_2x1.sv
// 2:1 lane selector with a combinational output and an enabled, asynchronously reset registered copy.
// An unknown sel resolves to lane0 in simulation, matching sel=0.
module mux_2x1 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   din,
    input  logic                 sel,
    input  logic                 en,
    output logic [WIDTH-1:0]     dout,
    output logic [WIDTH-1:0]     dout_q
);

    logic [WIDTH-1:0] w_lane0;
    logic [WIDTH-1:0] w_lane1;
    logic [WIDTH-1:0] w_sel_lane;
    logic [WIDTH-1:0] r_dout_q;

    assign w_lane0 = din[WIDTH-1:0];
    assign w_lane1 = din[2*WIDTH-1:WIDTH];

    // if() on an X/Z sel takes the default branch, so lane0 is selected.
    always_comb begin
        w_sel_lane = w_lane0;
        if (sel == 1'b1) begin
            w_sel_lane = w_lane1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_q <= RST_VAL;
        end else if (en) begin
            r_dout_q <= w_sel_lane;
        end
    end

    assign dout   = w_sel_lane;
    assign dout_q = r_dout_q;

endmodule

// File: tb/tb_mux_2x1.sv
// Directed-vector bench for mux_2x1: one WIDTH=1 instance and one WIDTH=8 instance with a non-zero reset value.
module tb_mux_2x1;

    logic        clk;
    logic        rst;
    logic [1:0]  din1;
    logic        sel1;
    logic        en1;
    logic        dout1;
    logic        dout_q1;
    logic [15:0] din8;
    logic        sel8;
    logic        en8;
    logic [7:0]  dout8;
    logic [7:0]  dout_q8;

    int n_checks = 0;
    int n_pass   = 0;

    mux_2x1 #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .din    (din1),
        .sel    (sel1),
        .en     (en1),
        .dout   (dout1),
        .dout_q (dout_q1)
    );

    mux_2x1 #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .din    (din8),
        .sel    (sel8),
        .en     (en8),
        .dout   (dout8),
        .dout_q (dout_q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] vec [4];
    logic       exp_s0 [4];
    logic       exp_s1 [4];

    initial begin
        vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
        exp_s0[0] = 1'b0; exp_s0[1] = 1'b1; exp_s0[2] = 1'b0; exp_s0[3] = 1'b1;
        exp_s1[0] = 1'b0; exp_s1[1] = 1'b0; exp_s1[2] = 1'b1; exp_s1[3] = 1'b1;

        rst  = 1'b1;
        din1 = 2'b00; sel1 = 1'b0; en1 = 1'b0;
        din8 = 16'h0000; sel8 = 1'b0; en8 = 1'b0;
        #1;
        check("rst_dout_q1", {7'b0, dout_q1}, 8'h00);
        check("rst_dout_q8", dout_q8, 8'h3C);

        // Combinational path stays live during reset.
        din1 = 2'b10; sel1 = 1'b1;
        #1;
        check("dout_in_rst", {7'b0, dout1}, 8'h01);

        @(negedge clk);
        rst = 1'b0;
        sel1 = 1'b0;

        for (int i = 0; i < 4; i++) begin
            din1 = vec[i];
            #1;
            check($sformatf("sel0_din%0d", i), {7'b0, dout1}, {7'b0, exp_s0[i]});
            #4;
        end
        sel1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din1 = vec[i];
            #1;
            check($sformatf("sel1_din%0d", i), {7'b0, dout1}, {7'b0, exp_s1[i]});
            #4;
        end

        din1 = 2'b10;
        sel1 = 1'b0; #1;
        check("toggle_sel0", {7'b0, dout1}, 8'h00);
        sel1 = 1'b1; #1;
        check("toggle_sel1", {7'b0, dout1}, 8'h01);

        // en=0 since reset: registered copies must still hold reset values.
        check("hold_en0_q1", {7'b0, dout_q1}, 8'h00);
        check("hold_en0_q8", dout_q8, 8'h3C);

        @(negedge clk);
        din1 = 2'b01; sel1 = 1'b0; en1 = 1'b1;
        #1;
        check("pre_edge_q1", {7'b0, dout_q1}, 8'h00);
        @(posedge clk); #1;
        check("capture_q1", {7'b0, dout_q1}, 8'h01);

        @(negedge clk);
        en1 = 1'b0; sel1 = 1'b1;
        @(posedge clk); #1;
        check("en0_hold_q1", {7'b0, dout_q1}, 8'h01);

        @(negedge clk);
        din8 = 16'hA55A; sel8 = 1'b0; en8 = 1'b1;
        #1;
        check("w8_sel0_dout", dout8, 8'h5A);
        @(posedge clk); #1;
        check("w8_sel0_q", dout_q8, 8'h5A);
        @(negedge clk);
        sel8 = 1'b1;
        #1;
        check("w8_sel1_dout", dout8, 8'hA5);
        check("w8_sel1_q_pre", dout_q8, 8'h5A);
        @(posedge clk); #1;
        check("w8_sel1_q", dout_q8, 8'hA5);

        // Asynchronous reset between edges; held across a posedge with en=1.
        @(negedge clk);
        din1 = 2'b01; sel1 = 1'b0; en1 = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_q1", {7'b0, dout_q1}, 8'h00);
        check("async_rst_q8", dout_q8, 8'h3C);
        @(posedge clk); #1;
        check("rst_held_q1", {7'b0, dout_q1}, 8'h00);
        check("rst_held_q8", dout_q8, 8'h3C);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_pre_q1", {7'b0, dout_q1}, 8'h00);
        @(posedge clk); #1;
        check("rel_cap_q1", {7'b0, dout_q1}, 8'h01);
        check("rel_cap_q8", dout_q8, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
